// File: rtl/mult3x3_accum_pkg.sv
// rtl/mult3x3_accum_pkg.sv - shared FSM encoding, operand widths and clog2 helper
package mac_pkg;

    localparam int OPND_W = 3;
    localparam int PROD_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult3x3_accum_if.sv
// rtl/mult3x3_accum_if.sv - operand input and result output handshakes of the MAC stage
interface mult3x3_accum_if #(
    parameter int ACC_W = 8
) ();
    import mac_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, acc_out
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, acc_out
    );
endinterface

// File: rtl/mult3x3_accum_mult.sv
// rtl/mult3x3_accum_mult.sv - combinational 3x3 unsigned multiplier
module mult_3x3
    import mac_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] out
);
    assign out = PROD_W'(a) * PROD_W'(b);
endmodule

// File: rtl/mult3x3_accum.sv
// rtl/mult3x3_accum.sv - sums N_TERMS products of 3-bit operand pairs into one result
module mult3x3_accum
    import mac_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int CNT_W   = 4,
    parameter int ACC_W   = 6 + clog2(N_TERMS)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    mult3x3_accum_if.slave bus
);

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ACC_W-1:0]   acc_out, acc_out_nxt;
    logic               out_valid, out_valid_nxt;
    logic               in_ready;
    logic               fire_in;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum;

    mult_3x3 u_mult (
        .a   (bus.a),
        .b   (bus.b),
        .out (prod)
    );

    assign prod_ext = ACC_W'(prod);
    assign sum      = acc + prod_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            acc_out   <= acc_out_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    // in_ready is a function of state only, so the source never sees a comb path from in_valid
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        acc_out_nxt   = acc_out;
        out_valid_nxt = out_valid;
        in_ready      = (state != DONE);
        fire_in       = bus.in_valid & in_ready;

        if (clear) begin
            state_nxt     = IDLE;
            acc_nxt       = '0;
            cnt_nxt       = '0;
            acc_out_nxt   = '0;
            out_valid_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire_in) begin
                        acc_nxt   = prod_ext;
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ACCUM;
                    end
                end
                ACCUM: begin
                    if (fire_in) begin
                        acc_nxt = sum;
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(N_TERMS - 1)) begin
                            state_nxt     = DONE;
                            acc_out_nxt   = sum;
                            out_valid_nxt = 1'b1;
                        end
                    end
                end
                DONE: begin
                    // result is held until taken; the next pair waits for IDLE
                    if (out_valid && bus.out_ready) begin
                        out_valid_nxt = 1'b0;
                        acc_nxt       = '0;
                        cnt_nxt       = '0;
                        state_nxt     = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.acc_out   = acc_out;

endmodule
